// File: rtl/systolic_row_feeder.sv
// systolic_row_feeder: accepts one tile of row-operand vectors and re-times
// them into the diagonal skew the MAC grid expects (lane i delayed i cycles),
// then flushes zeros until the tile has crossed the grid and pulses tile_done.

// One skew lane: a free-running shift chain of DEPTH registers.
module row_skew_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DEPTH-1:0][DATA_WIDTH-1:0] chain_q, chain_d;

  // Head loads the lane value; every other stage takes its predecessor.
  always_comb begin
    chain_d    = chain_q;
    chain_d[0] = din;
    for (int j = 1; j < DEPTH; j++) chain_d[j] = chain_q[j-1];
  end

  // Chain never stalls; reset clears in-flight operands.
  always_ff @(posedge clk) begin
    if (rst) chain_q <= '0;
    else     chain_q <= chain_d;
  end

  assign dout = chain_q[DEPTH-1];
endmodule

module systolic_row_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_SIZE = 4,
  parameter int K_DEPTH    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_data,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_row,
  output logic                             busy,
  output logic                             tile_done
);
  localparam int VC_W = $clog2(K_DEPTH + 1);
  localparam int FL_W = $clog2(2*ARRAY_SIZE - 1);
  localparam logic [VC_W-1:0] K_LAST     = VC_W'(K_DEPTH);
  localparam logic [FL_W-1:0] FLUSH_LAST = FL_W'(2*ARRAY_SIZE - 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [VC_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [FL_W-1:0] flush_cnt_q, flush_cnt_d;
  logic            accept;

  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] lane_in, lane_out;

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign busy      = (state_q != S_IDLE);
  assign tile_done = (state_q == S_DONE);
  assign accept    = in_valid && in_ready;

  // Non-accepted cycles feed zeros so bubbles stay diagonally aligned.
  always_comb begin
    lane_in = '0;
    if (accept) lane_in = in_data;
  end

  // Lane i gets i+1 stages: lane 0 shows data right after the accept edge.
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    row_skew_lane #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(i + 1)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .din  (lane_in[i]),
      .dout (lane_out[i])
    );
  end

  assign out_row = lane_out;

  // Tile sequencing: count accepts, then 2N-1 flush cycles, then one DONE.
  always_comb begin
    state_d     = state_q;
    vec_cnt_d   = vec_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          vec_cnt_d   = VC_W'(1);
          flush_cnt_d = '0;
          state_d     = (K_DEPTH == 1) ? S_FLUSH : S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          vec_cnt_d = vec_cnt_q + VC_W'(1);
          if (vec_cnt_q + VC_W'(1) == K_LAST) begin
            flush_cnt_d = '0;
            state_d     = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) state_d = S_DONE;
        else flush_cnt_d = flush_cnt_q + FL_W'(1);
      end
      S_DONE: begin
        vec_cnt_d   = '0;
        flush_cnt_d = '0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state; reset aborts any tile without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vec_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      vec_cnt_q   <= vec_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
endmodule

// File: tb/tb_systolic_row_feeder.sv
// Bench for systolic_row_feeder: directed tiles, expected skewed lanes and
// control timing pushed at issue time, checked by an independent monitor.
module tb_systolic_row_feeder;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int W   = N*DW;
  localparam int BIG = 1 << 30;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         iv0 = 1'b0, iv1 = 1'b0;
  logic [W-1:0] din = '0;
  logic         ir0, ir1, bz0, bz1, td0, td1;
  logic [W-1:0] or0, or1;

  systolic_row_feeder #(.DATA_WIDTH(DW), .ARRAY_SIZE(N), .K_DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_data(din),
    .out_row(or0), .busy(bz0), .tile_done(td0));

  systolic_row_feeder #(.DATA_WIDTH(DW), .ARRAY_SIZE(N), .K_DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_data(din),
    .out_row(or1), .busy(bz1), .tile_done(td1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0, nerr = 0;
  bit mon_en = 1'b0, sel = 1'b0;
  int busy_lo = BIG, busy_hi = BIG, nr_lo = BIG, nr_hi = BIG;
  logic [DW-1:0] exp_a [int];
  int done_q [$];

  task automatic chk(input string nm, input logic [W-1:0] a, input logic [W-1:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, a, e);
    end
  endtask

  task automatic chk1(input string nm, input logic a, input logic e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] mk(input int a, input int b, input int c, input int d);
    return {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  // Drive a vector expected to be accepted at the next edge e.
  task automatic send(input logic [W-1:0] v, input bit first, input bit last);
    int e;
    e = cyc + 1;
    if (sel) iv1 = 1'b1; else iv0 = 1'b1;
    din = v;
    if (first) begin busy_lo = e; busy_hi = BIG; end
    for (int i = 0; i < N; i++) exp_a[(e+i)*N + i] = v[i*DW +: DW];
    if (last) begin
      nr_lo   = e;
      nr_hi   = e + 2*N - 1;
      busy_hi = e + 2*N - 1;
      done_q.push_back(e + 2*N - 1);
    end
    step();
  endtask

  // Non-accepted cycles; hv keeps in_valid high with junk data.
  task automatic idle(input int n, input bit hv);
    if (sel) iv1 = hv; else iv0 = hv;
    din = 32'hA5C3_5A3C;
    repeat (n) step();
  endtask

  // Reset at the next edge r: everything from r on reads as idle/zero.
  task automatic reset_mid();
    int r;
    r = cyc + 1;
    rst = 1'b1; iv0 = 1'b0; iv1 = 1'b0;
    for (int c = r; c <= r + N; c++)
      for (int i = 0; i < N; i++)
        if (exp_a.exists(c*N + i)) exp_a.delete(c*N + i);
    done_q.delete();
    if (busy_hi >= r) busy_hi = r - 1;
    if (nr_hi >= r)   nr_hi   = r - 1;
    step();
    rst = 1'b0;
  endtask

  // Monitor: compare selected DUT's outputs with the expectations each cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [W-1:0] er;
      logic e_done;
      int t;
      t = cyc;
      for (int i = 0; i < N; i++)
        er[i*DW +: DW] = exp_a.exists(t*N + i) ? exp_a[t*N + i] : '0;
      chk("out_row", sel ? or1 : or0, er);
      chk1("in_ready", sel ? ir1 : ir0, !(t >= nr_lo && t <= nr_hi));
      chk1("busy", sel ? bz1 : bz0, (t >= busy_lo && t <= busy_hi));
      e_done = (done_q.size() > 0) && (done_q[0] == t);
      chk1("tile_done", sel ? td1 : td0, e_done);
      if (e_done) void'(done_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    step();
    mon_en = 1'b1;
    step();
    rst = 1'b0;

    // back-to-back tile, in_valid held with junk during FLUSH/DONE
    for (int k = 0; k < 4; k++) send(mk(10*k, 10*k+1, 10*k+2, 10*k+3), k == 0, k == 3);
    idle(2*N, 1'b1);

    // signed tile, accepted at the earliest re-accept edge
    send(mk(-128, -1, 127, 0), 1'b1, 1'b0);
    send(mk(1, 2, 3, 4), 1'b0, 1'b0);
    send(mk(-5, -6, -7, -8), 1'b0, 1'b0);
    send(mk(127, -128, 1, -1), 1'b0, 1'b1);
    idle(2*N, 1'b0);

    // bubble of two cycles between v1 and v2
    send(mk(11, 12, 13, 14), 1'b1, 1'b0);
    send(mk(21, 22, 23, 24), 1'b0, 1'b0);
    idle(2, 1'b0);
    send(mk(31, 32, 33, 34), 1'b0, 1'b0);
    send(mk(41, 42, 43, 44), 1'b0, 1'b1);
    idle(2*N, 1'b0);

    // reset three cycles into FLUSH, then a clean tile
    for (int k = 0; k < 4; k++) send(mk(50+k, 60+k, 70+k, 80+k), k == 0, k == 3);
    idle(2, 1'b0);
    reset_mid();
    for (int k = 0; k < 4; k++) send(mk(10*k, 10*k+1, 10*k+2, 10*k+3), k == 0, k == 3);
    idle(2*N, 1'b0);
    idle(2, 1'b0);

    // K_DEPTH=1 instance with in_valid held high across tiles
    sel = 1'b1;
    send(mk(7, 8, 9, 10), 1'b1, 1'b1);
    idle(2*N, 1'b1);
    send(mk(-7, -8, -9, -10), 1'b1, 1'b1);
    idle(2*N, 1'b1);
    send(mk(100, 101, 102, 103), 1'b1, 1'b1);
    idle(2*N, 1'b0);
    idle(2, 1'b0);

    nvec++;
    if (done_q.size() != 0) begin
      nerr++;
      $display("FAIL pending_done got=%0d want=0", done_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
